// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative shift-add
// multiply and restoring unsigned divide, with valid/ready on both sides.
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   Sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic [3:0]   flag
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_next;
  logic [N-1:0]    a_r, b_r;
  logic [2*N-1:0]  acc, acc_next;
  logic [CW-1:0]   cnt;
  logic            accept, last;

  logic [N:0]      sum_add, sum_sub, mul_sum, div_shift, div_diff;
  logic [N-1:0]    alu_res, it_res;
  logic            alu_c, alu_v, it_c, it_v;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last      = (cnt == CW'(N - 1));

  // Single-cycle ops, evaluated directly on the presented operands.
  always_comb begin
    sum_add = {1'b0, A} + {1'b0, B};
    sum_sub = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (Sel)
      3'b000: begin
        alu_res = sum_add[N-1:0];
        alu_c   = sum_add[N];
        alu_v   = (A[N-1] == B[N-1]) && (sum_add[N-1] != A[N-1]);
      end
      3'b001: begin
        alu_res = sum_sub[N-1:0];
        alu_c   = sum_sub[N];
        alu_v   = (A[N-1] != B[N-1]) && (sum_sub[N-1] != A[N-1]);
      end
      3'b010:  alu_res = A & B;
      3'b011:  alu_res = A | B;
      3'b101:  alu_res = B;
      3'b111:  alu_res = A ^ B;
      default: alu_res = '0;
    endcase
  end

  // acc is {high product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_r} : '0);
    div_shift = {acc[2*N-1:N], acc[N-1]};
    div_diff  = div_shift - {1'b0, b_r};
    acc_next  = acc;
    it_res    = '0;
    it_c      = 1'b0;
    it_v      = 1'b0;
    case (state)
      MUL: begin
        acc_next = {mul_sum, acc[N-1:1]};
        it_res   = acc_next[N-1:0];
        it_c     = |acc_next[2*N-1:N];
      end
      DIV: begin
        if (!div_diff[N])
          acc_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
        else
          acc_next = {div_shift[N-1:0], acc[N-2:0], 1'b0};
        it_v   = (b_r == '0);
        it_res = it_v ? '1 : acc_next[N-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        case (Sel)
          3'b100:  state_next = MUL;
          3'b110:  state_next = DIV;
          default: state_next = DONE;
        endcase
      end
      MUL, DIV: if (last) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      Out  <= '0;
      flag <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r <= A;
          b_r <= B;
          cnt <= '0;
          acc <= {{N{1'b0}}, (Sel == 3'b110) ? A : B};
          if (Sel != 3'b100 && Sel != 3'b110) begin
            Out  <= alu_res;
            flag <= {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            Out  <= it_res;
            flag <= {it_res[N-1], (it_res == '0), it_c, it_v};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_alu_seq;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A, B;
  logic [2:0]    Sel;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  Out;
  logic [3:0]    flag;

  int total = 0;
  int bad   = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] out;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sel);
    longint sa, sb, s;
    logic [63:0] p;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = '0;
    case (sel)
      3'd0: begin
        p = 64'(a) + 64'(b); r = p[31:0]; c = p[32];
        s = sa + sb; v = (s != longint'($signed(r)));
      end
      3'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin
        p = 64'(a) * 64'(b); r = p[31:0]; c = (p[63:32] != 0);
      end
      3'd5: r = b;
      3'd6: begin
        if (b == 0) begin r = '1; v = 1'b1; end
        else r = a / b;
      end
      default: r = a ^ b;
    endcase
    return {r, r[31], (r == 0), c, v};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    A = a; B = b; Sel = sel; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Sel = 3'($urandom);
  endtask

  // Returns cycle index (relative to acceptance edge) at which out_valid shows.
  task automatic wait_out(output int cyc, output bit ready_seen);
    cyc = 1;
    ready_seen = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    if (in_ready) ready_seen = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] sel, input logic [31:0] eo, input logic [3:0] ef);
    int cyc;
    bit rs;
    int exp_lat;
    exp_lat = (sel == 3'd4 || sel == 3'd6) ? N + 1 : 1;
    issue(a, b, sel);
    wait_out(cyc, rs);
    chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({name, "_busy"}, 64'(rs), 64'd0);
    chk({name, "_out"}, 64'(Out), 64'(eo));
    chk({name, "_flag"}, 64'(flag), 64'(ef));
  endtask

  initial begin
    logic [35:0] m;
    logic [31:0] ra, rb;
    logic [2:0]  rs;
    int cyc;
    bit seen;

    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 4'b1001};
    vecs[1]  = '{32'h00000005, 32'h00000005, 3'd1, 32'h00000000, 4'b0110};
    vecs[2]  = '{32'h00000003, 32'h00000005, 3'd1, 32'hFFFFFFFE, 4'b1000};
    vecs[3]  = '{32'h00010000, 32'h00010000, 3'd4, 32'h00000000, 4'b0110};
    vecs[4]  = '{32'h00000007, 32'h00000006, 3'd4, 32'h0000002A, 4'b0000};
    vecs[5]  = '{32'h00000064, 32'h00000007, 3'd6, 32'h0000000E, 4'b0000};
    vecs[6]  = '{32'h00000009, 32'h00000000, 3'd6, 32'hFFFFFFFF, 4'b1001};
    vecs[7]  = '{32'hF0F0F0F0, 32'hFFFF0000, 3'd7, 32'h0F0FF0F0, 4'b0000};
    vecs[8]  = '{32'hF0F0F0F0, 32'hFFFF0000, 3'd2, 32'hF0F00000, 4'b1000};
    vecs[9]  = '{32'h00000000, 32'h00000000, 3'd3, 32'h00000000, 4'b0100};
    vecs[10] = '{32'h00000123, 32'h80000001, 3'd5, 32'h80000001, 4'b1000};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 4'b0110};
    vecs[12] = '{32'h80000000, 32'h00000001, 3'd1, 32'h7FFFFFFF, 4'b0011};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(Out), 64'd0);
    chk("rst_flag", 64'(flag), 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel,
             vecs[i].out, vecs[i].flg);

    // Backpressure: result held, new requests ignored while DONE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(32'hF0F0F0F0, 32'hFFFF0000, 3'd7);
    wait_out(cyc, seen);
    chk("bp_lat", 64'(cyc), 64'd1);
    A = 32'h1; B = 32'h1; Sel = 3'd0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_hold", 64'(Out), 64'h0F0FF0F0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_out_hold", 64'(Out), 64'h0F0FF0F0);
    chk("bp_idle_flag_hold", 64'(flag), 64'd0);

    // Reset during the 10th multiply iteration discards everything.
    issue(32'h12345678, 32'h9ABCDEF0, 3'd4);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_mul_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out", 64'(Out), 64'd0);
    chk("abort_flag", 64'(flag), 64'd0);
    run_op("post_abort_add", 32'd2, 32'd2, 3'd0, 32'd4, 4'b0000);

    // Randomized operations against the reference model.
    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 3'($urandom_range(0, 7));
      if (($urandom & 3) == 0) rb = 32'($urandom_range(0, 15));
      if (($urandom & 7) == 0) ra = rb;
      m = model(ra, rb, rs);
      run_op($sformatf("rnd%0d_sel%0d", k, rs), ra, rb, rs, m[35:4], m[3:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
